// File: rtl/tri_dispatch_arb_if.sv
// Port bundle for tri_dispatch_arb: two triangle requesters, the R10 rasterizer port and the issue counters.
// Coordinates are fixed point and pass through untouched, so the fraction width never appears here.
interface tri_dispatch_arb_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int CNT_W  = 16
);
    // Requester n transfers in a cycle where valid_n and ready_n are both 1; ready_n is
    // combinational and a requester holds its data while valid_n=1 and ready_n=0.
    // Rast consumes R10 in a cycle where validTri_R10H=1 and halt_RnnnnL=1.
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri0_S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color0_U;
    logic                                          valid0_H;
    logic                                          ready0_H;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri1_S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color1_U;
    logic                                          valid1_H;
    logic                                          ready1_H;
    logic                                          halt_RnnnnL;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R10S;
    logic        [COLORS-1:0][SIGFIG-1:0]          color_R10U;
    logic                                          validTri_R10H;
    logic                                          grant_id_R10H;
    logic        [CNT_W-1:0]                       tri_cnt0_U;
    logic        [CNT_W-1:0]                       tri_cnt1_U;
    logic        [1:0]                             fsm_state;

    modport master (
        output tri0_S, color0_U, valid0_H, tri1_S, color1_U, valid1_H, halt_RnnnnL,
        input  ready0_H, ready1_H, tri_R10S, color_R10U, validTri_R10H, grant_id_R10H,
        input  tri_cnt0_U, tri_cnt1_U, fsm_state
    );

    modport slave (
        input  tri0_S, color0_U, valid0_H, tri1_S, color1_U, valid1_H, halt_RnnnnL,
        output ready0_H, ready1_H, tri_R10S, color_R10U, validTri_R10H, grant_id_R10H,
        output tri_cnt0_U, tri_cnt1_U, fsm_state
    );
endinterface

// File: rtl/tri_dispatch_arb.sv
// Round-robin/burst arbiter sharing the rast R10 triangle port between two producers.
// Define TRI_DISPATCH_FIXED_PRIO_EN to give requester 0 strict priority instead.
module tri_dispatch_arb #(
    parameter int BURST_MAX = 2
) (
    input logic               clk,
    input logic               rst,
    tri_dispatch_arb_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state, state_n;
    logic   load_en;
    logic   win0, win1;

    // The R10 register can take a new triangle when empty or being consumed this cycle.
    assign load_en       = !bus.validTri_R10H || bus.halt_RnnnnL;
    assign bus.ready0_H  = load_en && win0 && rst;
    assign bus.ready1_H  = load_en && win1 && rst;
    assign bus.fsm_state = state;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

`ifdef TRI_DISPATCH_FIXED_PRIO_EN
    always_comb begin
        win0    = 1'b0;
        win1    = 1'b0;
        state_n = state;
        if (load_en) begin
            win0 = bus.valid0_H;
            win1 = !bus.valid0_H && bus.valid1_H;
            if (win0)      state_n = OWN0;
            else if (win1) state_n = OWN1;
            else           state_n = IDLE;
        end
    end
`else
    localparam int            BW         = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

    logic [BW-1:0] burst_cnt, burst_cnt_n;
    logic          rr_ptr, rr_ptr_n;

    // rr_ptr resets to 1 so requester 0 is preferred first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            burst_cnt <= '0;
            rr_ptr    <= 1'b1;
        end else begin
            burst_cnt <= burst_cnt_n;
            rr_ptr    <= rr_ptr_n;
        end
    end

    always_comb begin
        win0        = 1'b0;
        win1        = 1'b0;
        state_n     = state;
        burst_cnt_n = burst_cnt;
        rr_ptr_n    = rr_ptr;
        if (load_en) begin
            case (state)
                IDLE: begin
                    if (rr_ptr) begin
                        win0 = bus.valid0_H;
                        win1 = !bus.valid0_H && bus.valid1_H;
                    end else begin
                        win1 = bus.valid1_H;
                        win0 = !bus.valid1_H && bus.valid0_H;
                    end
                    if (win0) begin
                        state_n     = OWN0;
                        burst_cnt_n = '0;
                    end else if (win1) begin
                        state_n     = OWN1;
                        burst_cnt_n = '0;
                    end
                end
                OWN0: begin
                    if (bus.valid0_H && (burst_cnt != BURST_LAST || !bus.valid1_H)) begin
                        win0 = 1'b1;
                        if (burst_cnt != BURST_LAST) burst_cnt_n = burst_cnt + 1'b1;
                    end else if (bus.valid1_H) begin
                        win1        = 1'b1;
                        state_n     = OWN1;
                        burst_cnt_n = '0;
                        rr_ptr_n    = 1'b0;
                    end else begin
                        state_n  = IDLE;
                        rr_ptr_n = 1'b0;
                    end
                end
                OWN1: begin
                    if (bus.valid1_H && (burst_cnt != BURST_LAST || !bus.valid0_H)) begin
                        win1 = 1'b1;
                        if (burst_cnt != BURST_LAST) burst_cnt_n = burst_cnt + 1'b1;
                    end else if (bus.valid0_H) begin
                        win0        = 1'b1;
                        state_n     = OWN0;
                        burst_cnt_n = '0;
                        rr_ptr_n    = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        rr_ptr_n = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end
`endif

    // Without a winner only the valid bit drops; data and grant_id keep their last value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.validTri_R10H <= 1'b0;
            bus.tri_R10S      <= '0;
            bus.color_R10U    <= '0;
            bus.grant_id_R10H <= 1'b0;
        end else if (load_en) begin
            bus.validTri_R10H <= win0 || win1;
            if (win0) begin
                bus.tri_R10S      <= bus.tri0_S;
                bus.color_R10U    <= bus.color0_U;
                bus.grant_id_R10H <= 1'b0;
            end else if (win1) begin
                bus.tri_R10S      <= bus.tri1_S;
                bus.color_R10U    <= bus.color1_U;
                bus.grant_id_R10H <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.tri_cnt0_U <= '0;
            bus.tri_cnt1_U <= '0;
        end else begin
            if (bus.valid0_H && bus.ready0_H) bus.tri_cnt0_U <= bus.tri_cnt0_U + 1'b1;
            if (bus.valid1_H && bus.ready1_H) bus.tri_cnt1_U <= bus.tri_cnt1_U + 1'b1;
        end
    end
endmodule
